// File: rtl/bsg_manycore_reset_sequencer.sv
// ---------------------------------------------------------------------------
// bsg_manycore_reset_sequencer
//
// Purpose: brings a manycore array out of reset in a controlled order. All
// resets are held for assert_cycles_p cycles. The IO router row is released
// first. Tile rows are then released one at a time, nearest the IO row first,
// with gap_cycles_p cycles between releases. When every row is out of reset,
// the block reports done and accepts a request to run the sequence again.
//
// Ports:
//   clk_i             - single clock; all state changes on its rising edge
//   reset_n_i         - asynchronous active-low reset; restarts the sequence
//   reset_req_v_i     - request to run the reset sequence again
//   reset_req_ready_o - high only when the sequence is done; a request is
//                       accepted when this and reset_req_v_i are both high
//   io_reset_o        - active-high reset for the IO router row
//   tile_reset_o      - active-high reset per tile row; bit 0 is the row
//                       next to the IO row
//   seq_done_o        - high when every reset output is released
//
// Every output comes straight from a flop. There is no combinational path
// from any input to any output.
// ---------------------------------------------------------------------------
module bsg_manycore_reset_sequencer #(
    parameter int num_tiles_y_p   = -1,
    parameter int assert_cycles_p = 16,
    parameter int gap_cycles_p    = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       reset_req_v_i,
    output logic                       reset_req_ready_o,
    output logic                       io_reset_o,
    output logic [num_tiles_y_p-2:0]   tile_reset_o,
    output logic                       seq_done_o
);

    // $clog2 that never returns 0, so a 1-entry range still gets a 1-bit field.
    function automatic int safe_clog2(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

    localparam int tile_rows_lp  = num_tiles_y_p - 1;
    localparam int max_cycles_lp = (assert_cycles_p > gap_cycles_p) ? assert_cycles_p : gap_cycles_p;
    localparam int cnt_w_lp      = safe_clog2(max_cycles_lp + 1);
    localparam int row_w_lp      = safe_clog2(tile_rows_lp);

    localparam logic [cnt_w_lp-1:0] assert_last_lp = cnt_w_lp'(assert_cycles_p - 1);
    localparam logic [cnt_w_lp-1:0] gap_last_lp    = cnt_w_lp'(gap_cycles_p - 1);
    localparam logic [row_w_lp-1:0] row_last_lp    = row_w_lp'(tile_rows_lp - 1);

    typedef enum logic [1:0] {
        eAssert,
        eStagger,
        eDone
    } state_e;

    state_e                  state_reg,      state_next;
    logic [cnt_w_lp-1:0]     count_reg,      count_next;
    logic [row_w_lp-1:0]     row_reg,        row_next;
    logic                    io_reset_reg,   io_reset_next;
    logic [tile_rows_lp-1:0] tile_reset_reg, tile_reset_next;
    logic                    done_reg,       done_next;
    logic                    ready_reg,      ready_next;

    // A row releases on the terminal count of each gap interval. The one-hot
    // mask selects the row currently pointed at by the row index.
    logic                    release_row;
    logic [tile_rows_lp-1:0] release_mask;

    assign release_row = (state_reg == eStagger) && (count_reg == gap_last_lp);

    genvar gi;
    generate
        for (gi = 0; gi < tile_rows_lp; gi++) begin : g_release
            assign release_mask[gi] = release_row && (row_reg == row_w_lp'(gi));
        end
    endgenerate

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg      <= eAssert;
            count_reg      <= '0;
            row_reg        <= '0;
            io_reset_reg   <= 1'b1;
            tile_reset_reg <= '1;
            done_reg       <= 1'b0;
            ready_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            count_reg      <= count_next;
            row_reg        <= row_next;
            io_reset_reg   <= io_reset_next;
            tile_reset_reg <= tile_reset_next;
            done_reg       <= done_next;
            ready_reg      <= ready_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        count_next      = count_reg;
        row_next        = row_reg;
        io_reset_next   = io_reset_reg;
        tile_reset_next = tile_reset_reg;
        done_next       = done_reg;
        ready_next      = ready_reg;

        case (state_reg)
            eAssert: begin
                if (count_reg == assert_last_lp) begin
                    state_next    = eStagger;
                    io_reset_next = 1'b0;
                    count_next    = '0;
                    row_next      = '0;
                end else begin
                    count_next = count_reg + cnt_w_lp'(1);
                end
            end
            eStagger: begin
                if (release_row) begin
                    // A released row is only ever set again by re-entering eAssert.
                    tile_reset_next = tile_reset_reg & ~release_mask;
                    count_next      = '0;
                    if (row_reg == row_last_lp) begin
                        state_next = eDone;
                        done_next  = 1'b1;
                        ready_next = 1'b1;
                    end else begin
                        row_next = row_reg + row_w_lp'(1);
                    end
                end else begin
                    count_next = count_reg + cnt_w_lp'(1);
                end
            end
            eDone: begin
                if (reset_req_v_i && ready_reg) begin
                    state_next      = eAssert;
                    io_reset_next   = 1'b1;
                    tile_reset_next = '1;
                    done_next       = 1'b0;
                    ready_next      = 1'b0;
                    count_next      = '0;
                    row_next        = '0;
                end
            end
            default: begin
                state_next = eAssert;
            end
        endcase
    end

    assign reset_req_ready_o = ready_reg;
    assign io_reset_o        = io_reset_reg;
    assign tile_reset_o      = tile_reset_reg;
    assign seq_done_o        = done_reg;

endmodule

// File: tb/tb_bsg_manycore_reset_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for bsg_manycore_reset_sequencer.
//
// Three instances run side by side with different parameter sets:
//   a: 3 rows, assert 4,  gap 2
//   b: 2 rows, assert 1,  gap 1
//   c: 9 rows, assert 16, gap 3
//
// A timing model tracks n, the number of edges since the sequence started.
// It derives the expected outputs from n alone:
//   io reset     is high while n < A
//   tile row i   is high while n < A + G*(i+1)
//   done / ready are high once n >= A + G*R
// Expected words are queued when a cycle is driven. They are popped and
// compared at the next falling edge.
// ---------------------------------------------------------------------------
module tb_bsg_manycore_reset_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    logic req_v;

    logic       ready_a, io_a, done_a;
    logic [1:0] tile_a;
    logic       ready_b, io_b, done_b;
    logic [0:0] tile_b;
    logic       ready_c, io_c, done_c;
    logic [7:0] tile_c;

    bsg_manycore_reset_sequencer #(
        .num_tiles_y_p(3), .assert_cycles_p(4), .gap_cycles_p(2)
    ) dut_a (
        .clk_i(clk), .reset_n_i(reset_n), .reset_req_v_i(req_v),
        .reset_req_ready_o(ready_a), .io_reset_o(io_a),
        .tile_reset_o(tile_a), .seq_done_o(done_a)
    );

    bsg_manycore_reset_sequencer #(
        .num_tiles_y_p(2), .assert_cycles_p(1), .gap_cycles_p(1)
    ) dut_b (
        .clk_i(clk), .reset_n_i(reset_n), .reset_req_v_i(req_v),
        .reset_req_ready_o(ready_b), .io_reset_o(io_b),
        .tile_reset_o(tile_b), .seq_done_o(done_b)
    );

    bsg_manycore_reset_sequencer #(
        .num_tiles_y_p(9), .assert_cycles_p(16), .gap_cycles_p(3)
    ) dut_c (
        .clk_i(clk), .reset_n_i(reset_n), .reset_req_v_i(req_v),
        .reset_req_ready_o(ready_c), .io_reset_o(io_c),
        .tile_reset_o(tile_c), .seq_done_o(done_c)
    );

    // Packed observation word: {ready, done, io, tile zero-extended to 13 bits}.
    logic [15:0] obs_a, obs_b, obs_c;
    assign obs_a = {ready_a, done_a, io_a, 11'b0, tile_a};
    assign obs_b = {ready_b, done_b, io_b, 12'b0, tile_b};
    assign obs_c = {ready_c, done_c, io_c, 5'b0,  tile_c};

    int n_a, n_b, n_c;
    int cyc;
    logic [15:0] q_a[$];
    logic [15:0] q_b[$];
    logic [15:0] q_c[$];

    int err_cnt = 0;
    int chk_cnt = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        chk_cnt++;
        if (obs !== expv) begin
            err_cnt++;
            $display("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
        end
    endtask

    function automatic logic [15:0] exp_out(input int n, input int a, input int g, input int r);
        logic [12:0] t;
        logic        io;
        logic        done;
        t = '0;
        for (int i = 0; i < r; i++) begin
            t[i] = (n < a + g * (i + 1));
        end
        io   = (n < a);
        done = (n >= a + g * r);
        return {done, done, io, t};
    endfunction

    // Edge count after the coming edge.
    // Reset holds the count at 0.
    // An accepted request in the done state restarts it at 0.
    function automatic int next_n(input int n, input int a, input int g, input int r,
                                  input logic v, input logic rn);
        if (!rn) return 0;
        if (v && (n >= a + g * r)) return 0;
        return (n < 1000) ? n + 1 : n;
    endfunction

    task automatic push_all();
        q_a.push_back(exp_out(n_a, 4, 2, 2));
        q_b.push_back(exp_out(n_b, 1, 1, 1));
        q_c.push_back(exp_out(n_c, 16, 3, 8));
    endtask

    task automatic pop_check(input string tag);
        logic [15:0] ea, eb, ec;
        ea = q_a.pop_front();
        eb = q_b.pop_front();
        ec = q_c.pop_front();
        check({tag, "/a"}, obs_a, ea);
        check({tag, "/b"}, obs_b, eb);
        check({tag, "/c"}, obs_c, ec);
    endtask

    // One clock cycle. The inputs are already set when this is called.
    task automatic step();
        n_a = next_n(n_a, 4, 2, 2, req_v, reset_n);
        n_b = next_n(n_b, 1, 1, 1, req_v, reset_n);
        n_c = next_n(n_c, 16, 3, 8, req_v, reset_n);
        push_all();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        $display("cyc=%0d rst_n=%0b v=%0b a=%h b=%h c=%h", cyc, reset_n, req_v, obs_a, obs_b, obs_c);
        pop_check("cycle");
    endtask

    initial begin
        reset_n = 1'b0;
        req_v   = 1'b0;
        n_a = 0; n_b = 0; n_c = 0;
        cyc = 0;

        // Reset state, with clocks running.
        @(negedge clk);
        push_all();
        pop_check("reset");
        repeat (3) step();

        // Full sequence with no request.
        reset_n = 1'b1;
        repeat (45) step();

        // Request held high from the first edge after reset.
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        req_v   = 1'b1;
        repeat (60) step();
        req_v = 1'b0;
        repeat (45) step();

        // Asynchronous abort in the middle of the staggered release. Instance a
        // has tile_reset 2'b10 at this point.
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        repeat (6) step();
        #1 reset_n = 1'b0;
        #1;
        n_a = 0; n_b = 0; n_c = 0;
        push_all();
        pop_check("async");
        step();
        step();
        reset_n = 1'b1;
        repeat (45) step();

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
